barrel_shifter_pipe: RTL and testbench
======================================

BARREL_SHIFTER_PIPE -- requirements
Module: barrel_shifter_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand width; SHALL be a power of two, 8 to 128; SHAMT_W = $clog2(DATA_WIDTH).
REQ-002 Parameter TAG_WIDTH, default 4: width of the user tag carried alongside each operand.
REQ-003 i_clk  input  1  single clock; all state updates on the rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_valid  input  1  upstream operand valid.
REQ-006 o_ready  output  1  block can accept an operand this cycle.
REQ-007 i_op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-008 i_shift_amt  input  SHAMT_W  shift distance, 0 to DATA_WIDTH-1.
REQ-009 i_data  input  DATA_WIDTH  operand.
REQ-010 i_tag  input  TAG_WIDTH  user tag, returned unmodified with the result.
REQ-011 o_valid  output  1  result valid.
REQ-012 i_ready  input  1  downstream accepts the result.
REQ-013 o_data  output  DATA_WIDTH  shifted result.
REQ-014 o_tag  output  TAG_WIDTH  tag of the operand that produced o_data.

Function
REQ-015 The block SHALL be a pipeline of SHAMT_W registered stages; stage k shifts by 2^(SHAMT_W-1-k) when the matching shift-amount bit is set (MSB first).
REQ-016 An input transfer SHALL occur when i_valid && o_ready; an output transfer SHALL occur when o_valid && i_ready.
REQ-017 Latency SHALL be exactly SHAMT_W cycles from an input transfer to o_valid, with no stalls in between.
REQ-018 Throughput SHALL be one operand per cycle when i_ready is held high.
REQ-019 Stall: o_ready = !(o_valid && !i_ready); while stalled, all stage registers, o_data and o_tag SHALL hold.
REQ-020 Bubbles (stage valid 0) SHALL advance whenever the pipeline is not stalled.
REQ-021 SLL fills with zeros from the LSB; SRL fills with zeros from the MSB.
REQ-022 SRA SHALL replicate i_data[DATA_WIDTH-1] into the vacated MSBs.
REQ-023 ROR SHALL rotate right, with bits leaving the LSB re-entering at the MSB.
REQ-024 Op, shift amount, sign bit and tag SHALL travel with the data through every stage, so mixed ops can be in flight together.
REQ-025 Shift amount 0 SHALL return i_data unchanged for every op.
REQ-026 o_data and o_tag SHALL only change on an output-stage load; while o_valid is 0 they hold their last value.

Reset
REQ-027 On i_rst_n low, all stage valid bits and o_valid SHALL clear to 0 immediately, and o_data and o_tag SHALL clear to 0.
REQ-028 Reset mid-operation SHALL discard all in-flight operands.
REQ-029 o_ready SHALL be 1 while in reset and in the first cycle after reset.

Configuration
REQ-030 Macro BARREL_SHIFTER_PIPE_ROTATE_EN:
  - When defined: op 11 performs ROR as in REQ-023.
  - When undefined: op 11 behaves as SRL, and no rotate wrap logic is built.

Verification
REQ-031 DATA_WIDTH=32, SRA, i_data=0x8000_00F0, amt=4 -> o_data=0xF800_000F, o_valid high 5 cycles later.
REQ-032 SLL, i_data=0x0000_0001, amt=31 -> 0x8000_0000; SRL, i_data=0xFFFF_FFFF, amt=31 -> 0x0000_0001.
REQ-033 ROR, i_data=0x0000_00A5, amt=4 -> 0x5000_000A with ROTATE_EN defined; 0x0000_000A without it.
REQ-034 Back-to-back stream of 8 mixed ops, tags 0-7, i_ready=1 -> 8 consecutive o_valid cycles, tags in order, each result matching a software model.
REQ-035 i_ready held low for 3 cycles while o_valid=1 -> o_ready=0, and o_data/o_tag stable; after release, no operand is lost or duplicated.
REQ-036 i_rst_n asserted with 3 operands in flight -> o_valid=0 at once and no stale result after release.

Source files
------------

// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: pipelined barrel shifter with one log2 stage per register and valid/ready flow control.
// Define BARREL_SHIFTER_PIPE_ROTATE_EN to make op 11 rotate right; otherwise op 11 acts as SRL.
module barrel_shifter_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [1:0]                    i_op,
    input  logic [$clog2(DATA_WIDTH)-1:0] i_shift_amt,
    input  logic [DATA_WIDTH-1:0]         i_data,
    input  logic [TAG_WIDTH-1:0]          i_tag,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic [TAG_WIDTH-1:0]          o_tag
);
    localparam int SHAMT_W = $clog2(DATA_WIDTH);
    localparam int L = SHAMT_W - 1;

    // The whole pipeline freezes as one unit when the result cannot leave.
    logic stall;
    assign stall   = o_valid && !i_ready;
    assign o_ready = !stall;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        localparam int DIST = 1 << (L - k);
        localparam int AW   = SHAMT_W - k;
        logic                  in_valid;
        logic                  in_sign;
        logic [1:0]            in_op;
        logic [AW-1:0]         in_amt;
        logic [DATA_WIDTH-1:0] in_data;
        logic [TAG_WIDTH-1:0]  in_tag;
        logic [DATA_WIDTH-1:0] srl;
        logic [DATA_WIDTH-1:0] rot;
        logic [DATA_WIDTH-1:0] data_d;
        logic                  valid_q;
        logic [DATA_WIDTH-1:0] data_q;
        logic [TAG_WIDTH-1:0]  tag_q;

        if (k == 0) begin : g_src
            assign in_valid = i_valid;
            assign in_sign  = i_data[DATA_WIDTH-1];
            assign in_op    = i_op;
            assign in_amt   = i_shift_amt;
            assign in_data  = i_data;
            assign in_tag   = i_tag;
        end else begin : g_src
            assign in_valid = g_stage[k-1].valid_q;
            assign in_sign  = g_stage[k-1].g_side.sign_q;
            assign in_op    = g_stage[k-1].g_side.op_q;
            assign in_amt   = g_stage[k-1].g_side.amt_q;
            assign in_data  = g_stage[k-1].data_q;
            assign in_tag   = g_stage[k-1].tag_q;
        end

        assign srl = in_data >> DIST;
`ifdef BARREL_SHIFTER_PIPE_ROTATE_EN
        assign rot = srl | (in_data << (DATA_WIDTH - DIST));
`else
        assign rot = srl;
`endif
        assign data_d = !in_amt[AW-1]    ? in_data :
                        in_op == 2'b00 ? in_data << DIST :
                        in_op == 2'b10 ? srl | ({DATA_WIDTH{in_sign}} << (DATA_WIDTH - DIST)) :
                        in_op == 2'b11 ? rot : srl;

        // Payload registers load only for real operands, so bubbles leave data untouched.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                tag_q   <= '0;
            end else if (!stall) begin
                valid_q <= in_valid;
                if (in_valid) begin
                    data_q <= data_d;
                    tag_q  <= in_tag;
                end
            end
        end

        // Op, sign and the not-yet-consumed amount bits ride along to the later stages.
        if (k < L) begin : g_side
            logic [1:0]    op_q;
            logic          sign_q;
            logic [AW-2:0] amt_q;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    op_q   <= '0;
                    sign_q <= 1'b0;
                    amt_q  <= '0;
                end else if (!stall && in_valid) begin
                    op_q   <= in_op;
                    sign_q <= in_sign;
                    amt_q  <= in_amt[AW-2:0];
                end
            end
        end
    end

    assign o_valid = g_stage[L].valid_q;
    assign o_data  = g_stage[L].data_q;
    assign o_tag   = g_stage[L].tag_q;
endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb_barrel_shifter_pipe: directed checks of latency, ops, streaming, stall and reset for a 32-bit barrel_shifter_pipe.
module tb_barrel_shifter_pipe;
    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [1:0]  i_op;
    logic [4:0]  i_shift_amt;
    logic [31:0] i_data;
    logic [3:0]  i_tag;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_data;
    logic [3:0]  o_tag;
    int checks = 0;
    int errors = 0;

`ifdef BARREL_SHIFTER_PIPE_ROTATE_EN
    localparam logic [31:0] ROR_EXP = 32'h5000_000A;
`else
    localparam logic [31:0] ROR_EXP = 32'h0000_000A;
`endif

    logic [1:0]  s_op   [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3};
    logic [4:0]  s_amt  [8] = '{5'd5, 5'd7, 5'd16, 5'd8, 5'd1, 5'd0, 5'd31, 5'd12};
    logic [31:0] s_data [8] = '{32'h1234_5678, 32'h8000_0001, 32'h8765_4321, 32'hDEAD_BEEF,
                                32'h7FFF_FFFE, 32'hCAFE_F00D, 32'h8000_0000, 32'h0F0F_1234};

    barrel_shifter_pipe dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_shift_amt(i_shift_amt), .i_data(i_data), .i_tag(i_tag),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_tag(o_tag)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] model(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d);
        logic signed [31:0] s;
        logic [63:0] dd;
        s  = d;
        dd = {d, d};
        case (op)
            2'd0:    return d << a;
            2'd1:    return d >> a;
            2'd2:    return s >>> a;
`ifdef BARREL_SHIFTER_PIPE_ROTATE_EN
            default: return dd[31:0] >> a | dd[63:32] << (6'd32 - {1'b0, a});
`else
            default: return d >> a;
`endif
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d, input logic [3:0] t);
        i_valid     = 1'b1;
        i_op        = op;
        i_shift_amt = a;
        i_data      = d;
        i_tag       = t;
    endtask

    // One isolated operand: o_valid must rise exactly 5 cycles after the transfer, then data holds.
    task automatic single(input string name, input logic [1:0] op, input logic [4:0] a,
                          input logic [31:0] d, input logic [3:0] t, input logic [31:0] exp);
        drive(op, a, d, t);
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        chk({name, "_early"}, o_valid, 0);
        @(negedge i_clk);
        chk({name, "_valid"}, o_valid, 1);
        chk({name, "_data"}, o_data, exp);
        chk({name, "_tag"}, o_tag, t);
        @(negedge i_clk);
        chk({name, "_drop"}, o_valid, 0);
        chk({name, "_hold"}, o_data, exp);
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_ready = 1'b1;
        i_valid = 1'b0;
        i_op = '0;
        i_shift_amt = '0;
        i_data = '0;
        i_tag = '0;
        #2;
        chk("rst_valid", o_valid, 0);
        chk("rst_ready", o_ready, 1);
        chk("rst_data", o_data, 0);
        chk("rst_tag", o_tag, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        chk("post_rst_ready", o_ready, 1);
        @(negedge i_clk);
        chk("post_rst_ready2", o_ready, 1);

        single("sra", 2'd2, 5'd4, 32'h8000_00F0, 4'd3, 32'hF800_000F);
        single("sll31", 2'd0, 5'd31, 32'h0000_0001, 4'd5, 32'h8000_0000);
        single("srl31", 2'd1, 5'd31, 32'hFFFF_FFFF, 4'd6, 32'h0000_0001);
        single("ror4", 2'd3, 5'd4, 32'h0000_00A5, 4'd7, ROR_EXP);
        single("sra0", 2'd2, 5'd0, 32'h9ABC_DEF0, 4'd9, 32'h9ABC_DEF0);
        single("ror0", 2'd3, 5'd0, 32'h1357_9BDF, 4'd10, 32'h1357_9BDF);

        // Back-to-back stream of mixed ops.
        for (int c = 0; c < 14; c++) begin
            chk("stream_valid", o_valid, (c >= 5 && c < 13) ? 1 : 0);
            chk("stream_ready", o_ready, 1);
            if (c >= 5 && c < 13) begin
                chk("stream_tag", o_tag, 64'(c - 5));
                chk("stream_data", o_data, model(s_op[c-5], s_amt[c-5], s_data[c-5]));
            end
            if (c < 8) drive(s_op[c], s_amt[c], s_data[c], 4'(c));
            else i_valid = 1'b0;
            @(negedge i_clk);
        end

        // Stall with a new operand waiting at the input.
        drive(2'd0, 5'd3, 32'h0000_1234, 4'd8);
        @(negedge i_clk);
        drive(2'd2, 5'd12, 32'hF000_0000, 4'd9);
        @(negedge i_clk);
        drive(2'd1, 5'd20, 32'hABCD_0000, 4'd10);
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (2) @(negedge i_clk);
        chk("stall_first_valid", o_valid, 1);
        chk("stall_first_tag", o_tag, 8);
        i_ready = 1'b0;
        drive(2'd2, 5'd1, 32'h4000_0000, 4'd11);
        #1;
        chk("stall_ready_low", o_ready, 0);
        for (int s = 0; s < 3; s++) begin
            @(negedge i_clk);
            chk("stall_valid", o_valid, 1);
            chk("stall_ready", o_ready, 0);
            chk("stall_tag", o_tag, 8);
            chk("stall_data", o_data, 32'h0000_91A0);
        end
        i_ready = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        chk("rel_tag9", o_tag, 9);
        chk("rel_data9", o_data, 32'hFFFF_0000);
        chk("rel_valid9", o_valid, 1);
        @(negedge i_clk);
        chk("rel_tag10", o_tag, 10);
        chk("rel_data10", o_data, 32'h0000_0ABC);
        chk("rel_valid10", o_valid, 1);
        @(negedge i_clk);
        chk("rel_gap1", o_valid, 0);
        @(negedge i_clk);
        chk("rel_gap2", o_valid, 0);
        @(negedge i_clk);
        chk("rel_valid11", o_valid, 1);
        chk("rel_tag11", o_tag, 11);
        chk("rel_data11", o_data, 32'h2000_0000);
        @(negedge i_clk);
        chk("rel_end", o_valid, 0);

        // Reset with operands in flight.
        drive(2'd0, 5'd1, 32'h0000_0001, 4'd12);
        @(negedge i_clk);
        drive(2'd1, 5'd1, 32'h0000_0004, 4'd13);
        @(negedge i_clk);
        drive(2'd2, 5'd1, 32'h8000_0000, 4'd14);
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (2) @(negedge i_clk);
        chk("pre_rst_valid", o_valid, 1);
        chk("pre_rst_tag", o_tag, 12);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_data", o_data, 0);
        chk("mid_rst_tag", o_tag, 0);
        chk("mid_rst_ready", o_ready, 1);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int r = 0; r < 8; r++) begin
            @(negedge i_clk);
            chk("no_stale", o_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
